div_round: RTL and testbench

- Post-processing stage directly downstream of the Goldschmidt divider datapath.
- Captures the raw quotient and remainder-sign bit after each division. Applies the one-ulp correction when the quotient overestimates, then rounds to OUTW bits with round-to-nearest-even.
- Buffers results in a 2-entry output queue with valid/ready handshake. The divider free-runs and cannot be stalled.

---
 rtl/div_round_if.sv | 28 ++
 rtl/div_round.sv | 132 +++++++++++++
 tb/tb_div_round.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_round_if.sv
// Handshake bundle between the divider post-processing stage and its consumer.
// The producer/consumer side uses master; div_round uses slave.
interface div_round_if #(
    parameter int WIDTH = 30,
    parameter int OUTW  = 24
);
    logic             in_valid;
    logic [WIDTH-1:0] quotient;
    logic             rem_sign;
    logic             out_ready;
    logic             clear_ovr;
    logic             out_valid;
    logic [OUTW-1:0]  result;
    logic             inexact;
    logic             sat;
    logic             overrun;
    logic [1:0]       count;

    modport master (
        output in_valid, quotient, rem_sign, out_ready, clear_ovr,
        input  out_valid, result, inexact, sat, overrun, count
    );

    modport slave (
        input  in_valid, quotient, rem_sign, out_ready, clear_ovr,
        output out_valid, result, inexact, sat, overrun, count
    );
endinterface

// File: rtl/div_round.sv
// Goldschmidt quotient post-processing: one-ulp correction, round-to-nearest-even
// to OUTW bits, and a 2-entry output queue with a sticky overrun flag.
module div_round #(
    parameter int WIDTH = 30,
    parameter int OUTW  = 24
) (
    input  logic         clk,
    input  logic         reset,
    div_round_if.slave   bus
);
    localparam int G  = WIDTH - OUTW;
    localparam int EW = OUTW + 2;

    generate
        if (G < 2) begin : g_bad_params
            $error("div_round: WIDTH-OUTW must be at least 2");
        end
    endgenerate

    // Stage S1: corrected quotient
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_qc_reg;
    logic             s1_unf_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s1_qc_reg    <= '0;
            s1_unf_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                if (!bus.rem_sign) begin
                    s1_qc_reg  <= bus.quotient;
                    s1_unf_reg <= 1'b0;
                end else if (bus.quotient != '0) begin
                    s1_qc_reg  <= bus.quotient - WIDTH'(1);
                    s1_unf_reg <= 1'b0;
                end else begin
                    s1_qc_reg  <= '0;
                    s1_unf_reg <= 1'b1;
                end
            end
        end
    end

    // Stage S2: rounding is combinational from S1; the queue write is its register
    logic [OUTW-1:0] trunc;
    logic            guard;
    logic            sticky;
    logic            round_up;
    logic            round_ovf;
    logic [EW-1:0]   s2_entry;

    assign trunc     = s1_qc_reg[WIDTH-1:G];
    assign guard     = s1_qc_reg[G-1];
    assign sticky    = |s1_qc_reg[G-2:0];
    assign round_up  = guard & (sticky | trunc[0]);
    assign round_ovf = (&trunc) & round_up;
    assign s2_entry  = {round_ovf ? {OUTW{1'b1}} : trunc + OUTW'(round_up),
                        guard | sticky | s1_unf_reg,
                        round_ovf | s1_unf_reg};

    // Output queue
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg;
    logic [1:0]    count_next;
    logic          overrun_reg;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [EW-1:0] entry [2];

    assign empty   = (count_reg == 2'd0);
    assign full    = (count_reg == 2'd2);
    assign pop     = !empty && bus.out_ready;
    // At full a simultaneous pop frees the head slot, which is exactly wr_ptr's slot
    assign push_ok = s1_valid_reg && (!full || pop);
    assign drop    = s1_valid_reg && full && !pop;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [EW-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= s2_entry;
                end
            end
            assign entry[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        unique case ({push_ok, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg  <= 1'b0;
            rd_ptr_reg  <= 1'b0;
            count_reg   <= 2'd0;
            overrun_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)     rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
            if (drop)
                overrun_reg <= 1'b1;
            else if (bus.clear_ovr)
                overrun_reg <= 1'b0;
        end
    end

    logic [EW-1:0] head;
    assign head = empty ? '0 : entry[rd_ptr_reg];

    assign bus.out_valid = !empty;
    assign bus.result    = head[EW-1:2];
    assign bus.inexact   = head[1];
    assign bus.sat       = head[0];
    assign bus.overrun   = overrun_reg;
    assign bus.count     = count_reg;
endmodule

// File: tb/tb_div_round.sv
// Self-checking bench for div_round: vector table plus random stream through a
// scoreboard, then hand-written backpressure, overrun and reset sequences.
module tb_div_round;
    localparam int WIDTH = 30;
    localparam int OUTW  = 24;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             rs;
        logic [OUTW-1:0]  res;
        logic             inx;
        logic             sat;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [OUTW+1:0] sb [$];

    div_round_if #(.WIDTH(WIDTH), .OUTW(OUTW)) bus ();
    div_round #(.WIDTH(WIDTH), .OUTW(OUTW)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rounding written as integer arithmetic on the corrected quotient
    function automatic logic [OUTW+1:0] model(input logic [WIDTH-1:0] q, input logic rs);
        longint qc, t, r, half;
        logic   unf, up, inx, st;
        unf  = rs && (q == 0);
        qc   = (rs && q != 0) ? longint'(q) - 1 : longint'(q);
        t    = qc >> (WIDTH - OUTW);
        r    = qc % (longint'(1) << (WIDTH - OUTW));
        half = longint'(1) << (WIDTH - OUTW - 1);
        up   = (r > half) || (r == half && t[0]);
        inx  = (r != 0) || unf;
        st   = unf;
        if (up) t = t + 1;
        if (t >= (longint'(1) << OUTW)) begin
            t  = (longint'(1) << OUTW) - 1;
            st = 1'b1;
        end
        return {t[OUTW-1:0], inx, st};
    endfunction

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got result 0x%0h, expected no output", bus.result);
            end else begin
                logic [OUTW+1:0] e;
                e = sb.pop_front();
                if ({bus.result, bus.inexact, bus.sat} !== e) begin
                    n_fail++;
                    $display("FAIL out_entry: got res=0x%0h inx=%0b sat=%0b expected res=0x%0h inx=%0b sat=%0b",
                             bus.result, bus.inexact, bus.sat, e[OUTW+1:2], e[1], e[0]);
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] q, input logic rs, input bit expect_out);
        bus.in_valid = 1'b1;
        bus.quotient = q;
        bus.rem_sign = rs;
        if (expect_out) sb.push_back(model(q, rs));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || bus.out_valid) && k < 60) begin
            tick();
            k++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{30'h10000040, 1'b0, 24'h400001, 1'b0, 1'b0};
        vecs[1] = '{30'h10000040, 1'b1, 24'h400001, 1'b1, 1'b0};
        vecs[2] = '{30'h10000020, 1'b0, 24'h400000, 1'b1, 1'b0};
        vecs[3] = '{30'h10000060, 1'b0, 24'h400002, 1'b1, 1'b0};
        vecs[4] = '{30'h3FFFFFE0, 1'b0, 24'hFFFFFF, 1'b1, 1'b1};
        vecs[5] = '{30'h00000000, 1'b1, 24'h000000, 1'b1, 1'b1};
        vecs[6] = '{30'h3FFFFFC0, 1'b0, 24'hFFFFFF, 1'b0, 1'b0};
        vecs[7] = '{30'h3FFFFFDF, 1'b0, 24'hFFFFFF, 1'b1, 1'b0};
        vecs[8] = '{30'h00000001, 1'b1, 24'h000000, 1'b0, 1'b0};

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.quotient  = '0;
        bus.rem_sign  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clear_ovr = 1'b0;
        tick();
        check("rst_state", {28'd0, bus.out_valid, bus.overrun, bus.count}, 32'd0);
        check("rst_head", {6'd0, bus.result, bus.inexact, bus.sat}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Latency: in_valid at t -> out_valid at t+2, popped at once
        bus.out_ready = 1'b1;
        send(30'h10000040, 1'b0, 1'b1);
        check("lat_t1_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("lat_t2_valid_cnt", {29'd0, bus.out_valid, bus.count}, {29'd0, 1'b1, 2'd1});
        tick();
        check("lat_cnt_after_pop", 32'(bus.count), 32'd0);

        // Table vectors, back to back; also guards the model against the hand values
        foreach (vecs[i]) begin
            check($sformatf("model_vec%0d", i), 32'(model(vecs[i].q, vecs[i].rs)),
                  32'({vecs[i].res, vecs[i].inx, vecs[i].sat}));
            bus.in_valid = 1'b1;
            bus.quotient = vecs[i].q;
            bus.rem_sign = vecs[i].rs;
            sb.push_back({vecs[i].res, vecs[i].inx, vecs[i].sat});
            tick();
        end
        bus.in_valid = 1'b0;
        drain();

        // Random stream at full throughput
        for (int i = 0; i < 24; i++) begin
            bus.in_valid = 1'b1;
            bus.quotient = ($urandom_range(0, 7) == 0) ? 30'd0 : 30'($urandom);
            bus.rem_sign = 1'($urandom);
            sb.push_back(model(bus.quotient, bus.rem_sign));
            tick();
        end
        bus.in_valid = 1'b0;
        drain();

        // Backpressure: fill, overrun on third, drain in order, clear overrun
        bus.out_ready = 1'b0;
        send(30'h40, 1'b0, 1'b1);
        repeat (11) tick();
        send(30'h80, 1'b0, 1'b1);
        repeat (11) tick();
        check("bp_full_cnt", 32'(bus.count), 32'd2);
        check("bp_no_ovr_yet", 32'(bus.overrun), 32'd0);
        send(30'hC0, 1'b0, 1'b0);
        tick();
        check("bp_ovr_set", {29'd0, bus.overrun, bus.count}, {29'd0, 1'b1, 2'd2});
        check("bp_head_hold", 32'(bus.result), 32'h1);
        bus.out_ready = 1'b1;
        drain();
        check("bp_empty_valid", 32'(bus.out_valid), 32'd0);
        bus.clear_ovr = 1'b1;
        tick();
        bus.clear_ovr = 1'b0;
        check("bp_ovr_clear", 32'(bus.overrun), 32'd0);

        // Push coinciding with pop at full
        bus.out_ready = 1'b0;
        send(30'h40, 1'b0, 1'b1);
        send(30'h80, 1'b0, 1'b1);
        tick();
        check("pp_full_cnt", 32'(bus.count), 32'd2);
        bus.in_valid = 1'b1;
        bus.quotient = 30'hC0;
        bus.rem_sign = 1'b0;
        sb.push_back(model(30'hC0, 1'b0));
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("pp_cnt_kept", {29'd0, bus.overrun, bus.count}, {29'd0, 1'b0, 2'd2});
        check("pp_head_next", 32'(bus.result), 32'h2);

        // Drop and clear_ovr in the same cycle: set wins
        send(30'h100, 1'b0, 1'b0);
        bus.clear_ovr = 1'b1;
        tick();
        bus.clear_ovr = 1'b0;
        check("ovr_set_wins", 32'(bus.overrun), 32'd1);
        bus.clear_ovr = 1'b1;
        tick();
        bus.clear_ovr = 1'b0;
        check("ovr_clear2", 32'(bus.overrun), 32'd0);
        bus.out_ready = 1'b1;
        drain();

        // Reset with one entry queued and one in S1
        bus.out_ready = 1'b0;
        send(30'h40, 1'b0, 1'b0);
        tick();
        check("rs_one_queued", 32'(bus.count), 32'd1);
        send(30'h80, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("rs_async_state", {28'd0, bus.out_valid, bus.overrun, bus.count}, 32'd0);
        check("rs_async_head", {6'd0, bus.result, bus.inexact, bus.sat}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rs_quiet%0d", i), {30'd0, bus.out_valid, bus.count != 2'd0}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
